// File: rtl/capa_sweep_ctrl_pkg.sv
// Shared types and helpers for the capacitance sweep sequencer.
package capa_sweep_pkg;

    // Sequencer phases; every busy phase lasts one settle period.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REF_RISE = 3'd1,
        REF_FALL = 3'd2,
        SET_CAP  = 3'd3,
        RISE     = 3'd4,
        FALL     = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Widest delay word the helper below can describe.
    localparam int unsigned MAX_TIME_W = 64;

    // Marker stored when a measurement window closes without a TDC strobe.
    function automatic logic [MAX_TIME_W-1:0] missing_word(input int unsigned width);
        logic [MAX_TIME_W-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < MAX_TIME_W; i++) begin
            if (i < width) w[i] = 1'b1;
        end
        return w;
    endfunction

    // Phases during which the TDC result is captured.
    function automatic logic is_window(input state_t s);
        return (s == REF_RISE) || (s == REF_FALL) || (s == RISE) || (s == FALL);
    endfunction

endpackage

// File: rtl/capa_sweep_ctrl_settle_timer.sv
// Phase timer: reloaded on every phase entry, flags the final cycle of the phase.
module settle_timer #(
    parameter int unsigned SETTLE_CYC = 7
) (
    input  logic clk,
    input  logic nrst,
    input  logic load,
    output logic last_cycle
);

    localparam int unsigned           CNT_W    = $clog2(SETTLE_CYC);
    localparam logic [CNT_W-1:0]      LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Count down from SETTLE_CYC-1 to zero; reload when a new phase starts.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (!nrst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last_cycle = (cnt == '0);

endmodule

// File: rtl/capa_sweep_ctrl.sv
// Capacitance sweep sequencer: reference delays, then per-code rise/fall TDC capture.
module capa_sweep_ctrl
    import capa_sweep_pkg::*;
#(
    parameter int unsigned N_STEPS    = 100,
    parameter int unsigned CODE_W     = 7,
    parameter int unsigned SETTLE_CYC = 7,
    parameter int unsigned TIME_W     = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    output logic              din,
    output logic              cap_en,
    output logic [CODE_W-1:0] cap_code,
    input  logic              meas_valid,
    input  logic [TIME_W-1:0] meas_time,
    output logic              busy,
    output logic              done,
    output logic              miss,
    output logic [TIME_W-1:0] ref_rise,
    output logic [TIME_W-1:0] ref_fall,
    input  logic [CODE_W-1:0] rd_addr,
    output logic [TIME_W-1:0] rd_rise,
    output logic [TIME_W-1:0] rd_fall
);

    localparam logic [CODE_W-1:0] LAST_STEP = CODE_W'(N_STEPS - 1);
    localparam logic [TIME_W-1:0] MISSING   = TIME_W'(missing_word(TIME_W));

    state_t              state;
    state_t              state_next;
    logic [CODE_W-1:0]   step;
    logic                last_cycle;
    logic                phase_load;
    logic                start_ok;
    logic                in_window;
    logic                window_end;
    logic                cap_seen;
    logic [TIME_W-1:0]   cap_time;
    logic [TIME_W-1:0]   win_result;

    logic [TIME_W-1:0]   rise_mem [N_STEPS];
    logic [TIME_W-1:0]   fall_mem [N_STEPS];

    settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
        .clk        (clk),
        .nrst       (nrst),
        .load       (phase_load),
        .last_cycle (last_cycle)
    );

    assign start_ok   = start && !abort && ((state == IDLE) || (state == DONE));
    assign in_window  = is_window(state);
    assign window_end = in_window && last_cycle && !abort;
    // A strobe in the window's final cycle still counts and overrides earlier ones.
    assign win_result = meas_valid ? meas_time : (cap_seen ? cap_time : MISSING);
    assign cap_code   = step;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; abort overrides everything, phases advance on the timer's last cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
        state_next = state;
        phase_load = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = REF_RISE;
                        phase_load = 1'b1;
                    end
                end
                REF_RISE: if (last_cycle) begin state_next = REF_FALL; phase_load = 1'b1; end
                REF_FALL: if (last_cycle) begin state_next = SET_CAP;  phase_load = 1'b1; end
                SET_CAP:  if (last_cycle) begin state_next = RISE;     phase_load = 1'b1; end
                RISE:     if (last_cycle) begin state_next = FALL;     phase_load = 1'b1; end
                FALL: begin
                    if (last_cycle) begin
                        state_next = (step == LAST_STEP) ? DONE : SET_CAP;
                        phase_load = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current phase.
    always_comb begin
        din    = 1'b0;
        cap_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state)
            REF_RISE: begin din = 1'b1; busy = 1'b1; end
            REF_FALL: begin busy = 1'b1; end
            SET_CAP:  begin cap_en = 1'b1; busy = 1'b1; end
            RISE:     begin din = 1'b1; cap_en = 1'b1; busy = 1'b1; end
            FALL:     begin cap_en = 1'b1; busy = 1'b1; end
            DONE:     begin done = 1'b1; end
            default:  ;
        endcase
    end

    // Cap-code step: cleared on start/abort, advanced at the end of each FALL except the last.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step <= '0;
        end else if (abort || start_ok) begin
            step <= '0;
        end else if ((state == FALL) && last_cycle && (step != LAST_STEP)) begin
            step <= step + CODE_W'(1);
        end
    end

    // Per-window capture of the latest TDC word; emptied at every window boundary.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cap_time <= '0;
            cap_seen <= 1'b0;
        end else if (!in_window || last_cycle || abort) begin
            cap_time <= '0;
            cap_seen <= 1'b0;
        end else if (meas_valid) begin
            cap_time <= meas_time;
            cap_seen <= 1'b1;
        end
    end

    // Sticky miss flag, cleared when a new sweep is accepted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            miss <= 1'b0;
        end else if (start_ok) begin
            miss <= 1'b0;
        end else if (window_end && !meas_valid && !cap_seen) begin
            miss <= 1'b1;
        end
    end

    // Reference delays written at the close of the two reference windows.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ref_rise <= '0;
            ref_fall <= '0;
        end else if (window_end) begin
            if (state == REF_RISE) ref_rise <= win_result;
            if (state == REF_FALL) ref_fall <= win_result;
        end
    end

    // Result RAM write port, addressed by the current step.
    always_ff @(posedge clk) begin
        // NOTE: RAM arrays are deliberately not reset so they map onto plain memory.
        if (nrst && window_end) begin
            if (state == RISE) rise_mem[step] <= win_result;
            if (state == FALL) fall_mem[step] <= win_result;
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_rise <= '0;
            rd_fall <= '0;
        end else if (rd_addr <= LAST_STEP) begin
            rd_rise <= rise_mem[rd_addr];
            rd_fall <= fall_mem[rd_addr];
        end else begin
            rd_rise <= '0;
            rd_fall <= '0;
        end
    end

endmodule

// File: tb/tb_capa_sweep_ctrl.sv
// Self-checking bench for capa_sweep_ctrl with a phase-schedule reference model.
module tb_capa_sweep_ctrl;

    localparam int N  = 6;
    localparam int CW = 3;
    localparam int S  = 7;
    localparam int TW = 16;
    localparam int P  = 2 + 3 * N;   // phases per full sweep

    logic          clk = 1'b0;
    logic          nrst, start, abort, meas_valid;
    logic [TW-1:0] meas_time;
    logic [CW-1:0] rd_addr;
    logic          din, cap_en, busy, done, miss;
    logic [CW-1:0] cap_code;
    logic [TW-1:0] ref_rise, ref_fall, rd_rise, rd_fall;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: expected RAM contents, validity, reference words and miss flag.
    logic [TW-1:0] m_rise [N];
    logic [TW-1:0] m_fall [N];
    bit            v_rise [N];
    bit            v_fall [N];
    logic [TW-1:0] m_ref_r, m_ref_f;
    bit            m_miss;

    capa_sweep_ctrl #(
        .N_STEPS(N), .CODE_W(CW), .SETTLE_CYC(S), .TIME_W(TW)
    ) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .din(din), .cap_en(cap_en), .cap_code(cap_code),
        .meas_valid(meas_valid), .meas_time(meas_time),
        .busy(busy), .done(done), .miss(miss),
        .ref_rise(ref_rise), .ref_fall(ref_fall),
        .rd_addr(rd_addr), .rd_rise(rd_rise), .rd_fall(rd_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_cap_en"}, cap_en, 0);
    endtask

    // Read one address; the value is sampled one clock after rd_addr is applied.
    task automatic rd(input int a, output logic [TW-1:0] r, output logic [TW-1:0] f);
        rd_addr = CW'(a);
        @(negedge clk);
        r = rd_rise;
        f = rd_fall;
    endtask

    task automatic readback_all(input string tag);
        logic [TW-1:0] r, f;
        for (int a = 0; a < (1 << CW); a++) begin
            rd(a, r, f);
            if (a >= N) begin
                chk($sformatf("%s_oor_rise%0d", tag, a), r, 0);
                chk($sformatf("%s_oor_fall%0d", tag, a), f, 0);
            end else begin
                if (v_rise[a]) chk($sformatf("%s_rise%0d", tag, a), r, m_rise[a]);
                if (v_fall[a]) chk($sformatf("%s_fall%0d", tag, a), f, m_fall[a]);
            end
        end
    endtask

    // One sweep, cycle by cycle from the phase schedule.
    //  mode: 0 random TDC, 1 directed clean, 2 directed with missing/double strobes
    //  stop_kind: 0 none, 1 abort, 2 reset, 3 start+abort; applied in cycle stop_rel
    //  busy_start_rel: cycle where a (to-be-ignored) start pulse is issued
    task automatic sweep(input int mode, input int stop_rel, input int stop_kind,
                         input int busy_start_rel);
        bit            w_seen;
        logic [TW-1:0] w_last;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        m_miss = 1'b0;
        w_seen = 1'b0;
        w_last = '0;
        for (int rel = 0; rel < P * S; rel++) begin
            int k, o, j, sub;
            bit e_din, e_cap, win, mv;
            logic [TW-1:0] mt, base;
            k   = rel / S;
            o   = rel % S;
            j   = (k >= 2) ? (k - 2) / 3 : 0;
            sub = (k >= 2) ? (k - 2) % 3 : -1;
            e_din = (k == 0) || (sub == 1);
            e_cap = (k >= 2);
            win   = (k < 2) || (sub != 0);
            start = 1'b0;

            chk($sformatf("busy@%0d", rel), busy, 1);
            chk($sformatf("done@%0d", rel), done, 0);
            chk($sformatf("din@%0d", rel), din, e_din);
            chk($sformatf("cap_en@%0d", rel), cap_en, e_cap);
            if (e_cap) chk($sformatf("cap_code@%0d", rel), cap_code, j);
            chk($sformatf("miss@%0d", rel), miss, m_miss);
            chk($sformatf("ref_rise@%0d", rel), ref_rise, m_ref_r);
            chk($sformatf("ref_fall@%0d", rel), ref_fall, m_ref_f);

            if (rel == stop_rel) begin
                meas_valid = 1'b0;
                if (stop_kind == 2) begin
                    nrst = 1'b0;
                    #1;
                    chk_idle("rst");
                    chk("rst_cap_code", cap_code, 0);
                    chk("rst_miss", miss, 0);
                    chk("rst_ref_rise", ref_rise, 0);
                    chk("rst_ref_fall", ref_fall, 0);
                    chk("rst_rd_rise", rd_rise, 0);
                    chk("rst_rd_fall", rd_fall, 0);
                    for (int a = 0; a < N; a++) begin
                        v_rise[a] = 1'b0;
                        v_fall[a] = 1'b0;
                    end
                    m_ref_r = '0;
                    m_ref_f = '0;
                    m_miss  = 1'b0;
                    @(negedge clk);
                    nrst = 1'b1;
                    chk_idle("post_rst");
                end else begin
                    abort = 1'b1;
                    if (stop_kind == 3) start = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    start = 1'b0;
                    chk_idle(stop_kind == 3 ? "start_abort_busy" : "abort");
                    @(negedge clk);
                    chk_idle(stop_kind == 3 ? "start_abort_hold" : "abort_hold");
                end
                return;
            end

            if (rel == busy_start_rel) start = 1'b1;

            // TDC behaviour for this cycle.
            mv = 1'b0;
            mt = '0;
            if (k == 0)        base = 16'd100;
            else if (k == 1)   base = 16'd200;
            else if (sub == 1) base = TW'(100 + 10 * j);
            else if (sub == 2) base = TW'(200 + 10 * j);
            else               base = 16'd999;
            if (mode == 0) begin
                if ($urandom_range(3) == 0) begin
                    mv = 1'b1;
                    mt = TW'($urandom);
                end
            end else if (mode == 2 && sub == 2 && j == 1) begin
                mv = 1'b0;
            end else if (mode == 2 && sub == 1 && j == 2) begin
                if (o == 1) begin mv = 1'b1; mt = 16'd50; end
                if (o == 6) begin mv = 1'b1; mt = 16'd60; end
            end else if (mode == 2 && sub == 2 && j == 3) begin
                if (o == S - 1) begin mv = 1'b1; mt = 16'd77; end
            end else if (o == 3) begin
                mv = 1'b1;
                mt = base;
            end
            meas_valid = mv;
            meas_time  = mt;

            // Model: last strobe in a window wins; a silent window stores all-ones.
            if (win) begin
                if (mv) begin
                    w_seen = 1'b1;
                    w_last = mt;
                end
                if (o == S - 1) begin
                    logic [TW-1:0] val;
                    val = w_seen ? w_last : {TW{1'b1}};
                    if (!w_seen) m_miss = 1'b1;
                    if (k == 0)        m_ref_r = val;
                    else if (k == 1)   m_ref_f = val;
                    else if (sub == 1) begin m_rise[j] = val; v_rise[j] = 1'b1; end
                    else               begin m_fall[j] = val; v_fall[j] = 1'b1; end
                    w_seen = 1'b0;
                end
            end
            @(negedge clk);
        end
        meas_valid = 1'b0;
        start      = 1'b0;
        chk("done_flag", done, 1);
        chk("done_busy", busy, 0);
        chk("done_cap_en", cap_en, 0);
        chk("done_din", din, 0);
        chk("done_miss", miss, m_miss);
        chk("done_ref_rise", ref_rise, m_ref_r);
        chk("done_ref_fall", ref_fall, m_ref_f);
    endtask

    initial begin
        logic [TW-1:0] r, f;
        nrst = 1'b0; start = 1'b0; abort = 1'b0;
        meas_valid = 1'b0; meas_time = '0; rd_addr = '0;
        m_ref_r = '0; m_ref_f = '0; m_miss = 1'b0;
        for (int a = 0; a < N; a++) begin v_rise[a] = 1'b0; v_fall[a] = 1'b0; end

        // Reset values.
        repeat (3) @(negedge clk);
        chk_idle("init");
        chk("init_miss", miss, 0);
        chk("init_cap_code", cap_code, 0);
        chk("init_ref_rise", ref_rise, 0);
        chk("init_rd_rise", rd_rise, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Directed full sweep: deterministic TDC answers, strobes in SET_CAP ignored.
        sweep(1, -1, 0, -1);
        chk("dir_ref_rise", ref_rise, 100);
        chk("dir_ref_fall", ref_fall, 200);
        chk("dir_miss", miss, 0);
        rd(2, r, f);
        chk("dir_rd_rise2", r, 120);
        rd(0, r, f);
        rd_addr = CW'(3);
        #1;
        chk("rd_latency_old", rd_rise, 100);
        @(negedge clk);
        chk("rd_latency_new_rise", rd_rise, 130);
        chk("rd_latency_new_fall", rd_fall, 230);
        rd(N, r, f);
        chk("rd_oor_rise", r, 0);
        chk("rd_oor_fall", f, 0);
        readback_all("dir");

        // Missing strobe and double/final-cycle strobes.
        sweep(2, -1, 0, -1);
        chk("miss_sticky", miss, 1);
        rd(1, r, f);
        chk("miss_fall1", f, 16'hFFFF);
        rd(2, r, f);
        chk("double_rise2", r, 60);
        rd(3, r, f);
        chk("final_cycle_fall3", f, 77);
        readback_all("miss");

        // Randomised sweeps; restarting from DONE.
        repeat (2) begin
            sweep(0, -1, 0, -1);
            readback_all("rand");
        end

        // start+abort from DONE: stays IDLE, done cleared.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_idle("start_abort_idle");
        @(negedge clk);
        chk_idle("start_abort_idle_hold");

        // Abort in SET_CAP of step 2, with an ignored start while busy earlier.
        sweep(0, 8 * S + 2, 1, 20);
        readback_all("abort");

        // start+abort together while busy.
        sweep(1, 12 * S + 4, 3, -1);
        readback_all("sa_busy");

        // Asynchronous reset mid-RISE at step 5, then a clean recovery sweep.
        sweep(0, (2 + 3 * 5 + 1) * S + 3, 2, -1);
        readback_all("post_rst");
        sweep(0, -1, 0, 30);
        readback_all("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
